// File: rtl/iob_cache_pkg.sv
// Shared cache definitions: line fill buffer state encoding and the helpers
// that derive beat-index and line widths from the cache geometry.
package iob_cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2
  } lfb_state_e;

  // Width of a beat index within one line.
  function automatic int unsigned calc_line2mem_w(input int unsigned word_off_w,
                                                  input int unsigned be_data_w,
                                                  input int unsigned fe_data_w);
    return word_off_w - $clog2(be_data_w / fe_data_w);
  endfunction

  // Width of one full cache line in bits.
  function automatic int unsigned calc_line_w(input int unsigned fe_data_w,
                                              input int unsigned word_off_w);
    return fe_data_w * (32'd1 << word_off_w);
  endfunction

endpackage

// File: rtl/line_fill_buffer_if.sv
// Line fill buffer bus: refill request and read-beat channel in, line write
// and critical-word forward out.
//   slave  : the line fill buffer side
//   master : the refill engine / cache controller side
interface line_fill_buffer_if
  import iob_cache_pkg::*;
#(
  parameter int unsigned FE_ADDR_W  = 32,
  parameter int unsigned FE_DATA_W  = 32,
  parameter int unsigned BE_DATA_W  = 32,
  parameter int unsigned WORD_OFF_W = 3
);
  localparam int unsigned BE_BYTE_W  = $clog2(BE_DATA_W / 8);
  localparam int unsigned LINE2MEM_W = calc_line2mem_w(WORD_OFF_W, BE_DATA_W, FE_DATA_W);
  localparam int unsigned LINE_W     = calc_line_w(FE_DATA_W, WORD_OFF_W);
  localparam int unsigned ADDR_LO    = BE_BYTE_W + LINE2MEM_W;

  logic                         replace;
  logic [FE_ADDR_W-1:ADDR_LO]   fill_addr;
  logic [WORD_OFF_W-1:0]        fill_word_off;
  logic                         read_valid;
  logic [LINE2MEM_W-1:0]        read_addr;
  logic [BE_DATA_W-1:0]         read_rdata;
  logic                         line_we;
  logic [FE_ADDR_W-1:ADDR_LO]   line_addr;
  logic [LINE_W-1:0]            line_wdata;
  logic                         fill_err;
  logic                         fwd_valid;
  logic [FE_DATA_W-1:0]         fwd_rdata;

  modport slave (
    input  replace, fill_addr, fill_word_off, read_valid, read_addr, read_rdata,
    output line_we, line_addr, line_wdata, fill_err, fwd_valid, fwd_rdata
  );

  modport master (
    output replace, fill_addr, fill_word_off, read_valid, read_addr, read_rdata,
    input  line_we, line_addr, line_wdata, fill_err, fwd_valid, fwd_rdata
  );

endinterface

// File: rtl/line_fill_buffer.sv
// Line fill buffer: collects backend read beats of a cache refill into a
// line register and writes the whole line to the data memory once every beat
// has arrived. An incomplete refill is discarded with a fill_err pulse.
// Optional critical-word forwarding is enabled by defining CACHE_FILL_FWD_EN.
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : line_fill_buffer_if.slave (replace/fill_addr/fill_word_off,
//           read_valid/read_addr/read_rdata in; line_we/line_addr/line_wdata,
//           fill_err, fwd_valid/fwd_rdata out)
module line_fill_buffer
  import iob_cache_pkg::*;
#(
  parameter int unsigned FE_ADDR_W  = 32,
  parameter int unsigned FE_DATA_W  = 32,
  parameter int unsigned BE_DATA_W  = 32,
  parameter int unsigned WORD_OFF_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  line_fill_buffer_if.slave  bus
);
  localparam int unsigned BE_BYTE_W  = $clog2(BE_DATA_W / 8);
  localparam int unsigned LINE2MEM_W = calc_line2mem_w(WORD_OFF_W, BE_DATA_W, FE_DATA_W);
  localparam int unsigned LINE_W     = calc_line_w(FE_DATA_W, WORD_OFF_W);
  localparam int unsigned ADDR_LO    = BE_BYTE_W + LINE2MEM_W;
  localparam int unsigned BEATS      = 32'd1 << LINE2MEM_W;

  lfb_state_e                 state_q;
  logic [BEATS-1:0]           bitmap_q;
  logic [BEATS-1:0]           bitmap_d;
  logic [LINE_W-1:0]          line_q;
  logic [FE_ADDR_W-1:ADDR_LO] line_addr_q;
  logic                       line_we_q;
  logic                       fill_err_q;

  // Bitmap including a beat arriving this cycle, so a beat coinciding with
  // the fall of replace counts toward completeness.
  always_comb begin
    bitmap_d = bitmap_q;
    if (state_q == FILL && bus.read_valid) begin
      bitmap_d[bus.read_addr] = 1'b1;
    end
  end

  // Refill FSM, beat storage and line write strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bitmap_q    <= '0;
      line_q      <= '0;
      line_addr_q <= '0;
      line_we_q   <= 1'b0;
      fill_err_q  <= 1'b0;
    end else begin
      line_we_q  <= 1'b0;
      fill_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.replace) begin
            line_addr_q <= bus.fill_addr;
            bitmap_q    <= '0;
            state_q     <= FILL;
          end
        end
        FILL: begin
          if (bus.read_valid) begin
            line_q[BE_DATA_W*bus.read_addr +: BE_DATA_W] <= bus.read_rdata;
          end
          bitmap_q <= bitmap_d;
          if (!bus.replace) begin
            if (&bitmap_d) begin
              state_q   <= COMMIT;
              line_we_q <= 1'b1;
            end else begin
              state_q    <= IDLE;
              fill_err_q <= 1'b1;
            end
          end
        end
        COMMIT: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.line_we    = line_we_q;
  assign bus.line_addr  = line_addr_q;
  assign bus.line_wdata = line_q;
  assign bus.fill_err   = fill_err_q;

`ifdef CACHE_FILL_FWD_EN
  localparam int unsigned BEAT_SEL_W = WORD_OFF_W - LINE2MEM_W;

  logic [WORD_OFF_W-1:0] word_off_q;
  logic                  fwd_done_q;
  logic                  fwd_valid_q;
  logic [FE_DATA_W-1:0]  fwd_rdata_q;
  logic [LINE2MEM_W-1:0] crit_beat_c;
  logic [WORD_OFF_W-1:0] crit_sub_c;
  logic [FE_DATA_W-1:0]  crit_word_c;

  // Split the critical word offset into beat index and word-within-beat.
  always_comb begin
    crit_beat_c = LINE2MEM_W'(word_off_q >> BEAT_SEL_W);
    crit_sub_c  = word_off_q & WORD_OFF_W'(BE_DATA_W / FE_DATA_W - 1);
    crit_word_c = bus.read_rdata[FE_DATA_W*crit_sub_c +: FE_DATA_W];
  end

  // One forward pulse per refill; fwd_done_q blocks re-pulsing on a retry.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_off_q  <= '0;
      fwd_done_q  <= 1'b0;
      fwd_valid_q <= 1'b0;
      fwd_rdata_q <= '0;
    end else begin
      fwd_valid_q <= 1'b0;
      if (state_q == IDLE && bus.replace) begin
        word_off_q <= bus.fill_word_off;
        fwd_done_q <= 1'b0;
      end else if (state_q == FILL && bus.read_valid && !fwd_done_q &&
                   bus.read_addr == crit_beat_c) begin
        fwd_valid_q <= 1'b1;
        fwd_rdata_q <= crit_word_c;
        fwd_done_q  <= 1'b1;
      end
    end
  end

  assign bus.fwd_valid = fwd_valid_q;
  assign bus.fwd_rdata = fwd_rdata_q;
`else
  logic unused_fwd;
  assign unused_fwd    = ^bus.fill_word_off;
  assign bus.fwd_valid = 1'b0;
  assign bus.fwd_rdata = '0;
`endif

endmodule

// File: tb/tb_line_fill_buffer.sv
// Randomized self-checking bench for line_fill_buffer (FE=BE=32, 8 beats).
// Each refill is described as a list of (beat index, data) pairs; the
// expected outcome is derived from that list: the line commits only if every
// index appears, the last write of an index wins, and the critical word is
// the first beat carrying the captured offset.
module tb_line_fill_buffer;
  localparam int unsigned FE_ADDR_W  = 32;
  localparam int unsigned FE_DATA_W  = 32;
  localparam int unsigned BE_DATA_W  = 32;
  localparam int unsigned WORD_OFF_W = 3;
  localparam int unsigned NBEATS     = 8;
  localparam int unsigned LINE_W     = 256;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  line_fill_buffer_if #(
    .FE_ADDR_W(FE_ADDR_W), .FE_DATA_W(FE_DATA_W),
    .BE_DATA_W(BE_DATA_W), .WORD_OFF_W(WORD_OFF_W)
  ) bus ();

  line_fill_buffer #(
    .FE_ADDR_W(FE_ADDR_W), .FE_DATA_W(FE_DATA_W),
    .BE_DATA_W(BE_DATA_W), .WORD_OFF_W(WORD_OFF_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed output pulses, stamped with the cycle they were seen in.
  int                 we_cyc[$];
  logic [31:5]        we_addr[$];
  logic [LINE_W-1:0]  we_data[$];
  int                 err_cyc[$];
  int                 fwd_cyc[$];
  logic [31:0]        fwd_dat[$];

  always @(negedge clk) begin
    if (bus.line_we) begin
      we_cyc.push_back(cyc);
      we_addr.push_back(bus.line_addr);
      we_data.push_back(bus.line_wdata);
    end
    if (bus.fill_err) err_cyc.push_back(cyc);
    if (bus.fwd_valid) begin
      fwd_cyc.push_back(cyc);
      fwd_dat.push_back(bus.fwd_rdata);
    end
  end

  // Beat list of the refill being described.
  int          q_idx[$];
  logic [31:0] q_dat[$];

  task automatic check(input string tag, input logic [LINE_W-1:0] got,
                       input logic [LINE_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " line_we"}, LINE_W'(bus.line_we), '0);
    check({tag, " fill_err"}, LINE_W'(bus.fill_err), '0);
    check({tag, " fwd_valid"}, LINE_W'(bus.fwd_valid), '0);
    check({tag, " line_addr"}, LINE_W'(bus.line_addr), '0);
    check({tag, " line_wdata"}, bus.line_wdata, '0);
    check({tag, " fwd_rdata"}, LINE_W'(bus.fwd_rdata), '0);
  endtask

  // Run one refill from the beat list; reset_after >= 0 asserts reset right
  // after that beat and abandons the refill.
  task automatic refill(input string tag, input logic [31:5] addr,
                        input logic [2:0] off, input bit last_on_fall,
                        input int reset_after);
    logic [31:0]       val[NBEATS];
    bit                seen[NBEATS];
    int                fwd_exp;
    logic [31:0]       fwd_d;
    int                f;
    bit                aborted;
    bit                complete;
    logic [LINE_W-1:0] line;

    we_cyc.delete(); we_addr.delete(); we_data.delete();
    err_cyc.delete(); fwd_cyc.delete(); fwd_dat.delete();
    for (int k = 0; k < NBEATS; k++) begin
      val[k] = '0;
      seen[k] = 1'b0;
    end
    fwd_exp = -1;
    fwd_d = '0;
    aborted = 1'b0;
    f = 0;

    // Request cycle; the concurrent beat must be ignored outside FILL.
    bus.replace = 1'b1;
    bus.fill_addr = addr;
    bus.fill_word_off = off;
    bus.read_valid = 1'b1;
    bus.read_addr = 3'($urandom);
    bus.read_rdata = $urandom;
    step();

    for (int i = 0; i < q_idx.size(); i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.read_valid = 1'b0;
        bus.read_addr = 3'($urandom);
        step();
      end
      bus.read_valid = 1'b1;
      bus.read_addr = 3'(q_idx[i]);
      bus.read_rdata = q_dat[i];
      if (last_on_fall && i == q_idx.size() - 1) bus.replace = 1'b0;
      seen[q_idx[i]] = 1'b1;
      val[q_idx[i]] = q_dat[i];
      if (fwd_exp < 0 && q_idx[i] == int'(off)) begin
        fwd_exp = cyc + 1;
        fwd_d = q_dat[i];
      end
      f = cyc;
      step();
      if (i == reset_after) begin
        reset = 1'b1;
        bus.replace = 1'b0;
        bus.read_valid = 1'b0;
        step();
        reset = 1'b0;
        check_reset_state({tag, " mid-fill reset"});
        aborted = 1'b1;
        break;
      end
    end

    if (!aborted && !last_on_fall) begin
      bus.replace = 1'b0;
      bus.read_valid = 1'b0;
      f = cyc;
      step();
    end

    // Trailing idle cycles with stray beats that must be ignored.
    bus.replace = 1'b0;
    for (int j = 0; j < 3; j++) begin
      bus.read_valid = 1'($urandom);
      bus.read_addr = 3'($urandom);
      bus.read_rdata = $urandom;
      step();
    end
    bus.read_valid = 1'b0;

    complete = !aborted;
    for (int k = 0; k < NBEATS; k++) if (!seen[k]) complete = 1'b0;
    for (int k = 0; k < NBEATS; k++) line[k*32 +: 32] = val[k];

    check({tag, " line_we count"}, LINE_W'(we_cyc.size()), LINE_W'(complete ? 1 : 0));
    if (complete && we_cyc.size() > 0) begin
      check({tag, " line_we cycle"}, LINE_W'(we_cyc[0]), LINE_W'(f + 1));
      check({tag, " line_addr"}, LINE_W'(we_addr[0]), LINE_W'(addr));
      check({tag, " line_wdata"}, we_data[0], line);
    end
    check({tag, " fill_err count"}, LINE_W'(err_cyc.size()),
          LINE_W'((!complete && !aborted) ? 1 : 0));
    if (!complete && !aborted && err_cyc.size() > 0)
      check({tag, " fill_err cycle"}, LINE_W'(err_cyc[0]), LINE_W'(f + 1));
`ifdef CACHE_FILL_FWD_EN
    check({tag, " fwd count"}, LINE_W'(fwd_cyc.size()), LINE_W'(fwd_exp >= 0 ? 1 : 0));
    if (fwd_exp >= 0 && fwd_cyc.size() > 0) begin
      check({tag, " fwd cycle"}, LINE_W'(fwd_cyc[0]), LINE_W'(fwd_exp));
      check({tag, " fwd_rdata"}, LINE_W'(fwd_dat[0]), LINE_W'(fwd_d));
    end
`else
    check({tag, " fwd count"}, LINE_W'(fwd_cyc.size()), '0);
`endif
  endtask

  task automatic seq_beats(input int first, input int last, input logic [31:0] base);
    for (int k = first; k <= last; k++) begin
      q_idx.push_back(k);
      q_dat.push_back(base + 32'(k));
    end
  endtask

  initial begin
    int perm[NBEATS];
    reset = 1'b1;
    bus.replace = 1'b0;
    bus.fill_addr = '0;
    bus.fill_word_off = '0;
    bus.read_valid = 1'b0;
    bus.read_addr = '0;
    bus.read_rdata = '0;
    step();
    step();
    check_reset_state("reset");
    reset = 1'b0;
    step();

    // Full refill, in order.
    q_idx.delete(); q_dat.delete();
    seq_beats(0, 7, 32'hA0);
    refill("full", 27'h1234, 3'd0, 1'b0, -1);

    // Replace falls after five beats.
    q_idx.delete(); q_dat.delete();
    seq_beats(0, 4, 32'h50);
    refill("partial", 27'h0777, 3'd2, 1'b0, -1);

    // Retry: four stale beats, then a full restart.
    q_idx.delete(); q_dat.delete();
    seq_beats(0, 3, 32'hB0);
    seq_beats(0, 7, 32'hC0);
    refill("retry", 27'h0abc, 3'd1, 1'b0, -1);

    // Critical word at offset 5.
    q_idx.delete(); q_dat.delete();
    seq_beats(0, 7, 32'h10);
    q_dat[5] = 32'hDEAD;
    refill("fwd", 27'h0055, 3'd5, 1'b0, -1);

    // Reset after beat 3, then a normal refill.
    q_idx.delete(); q_dat.delete();
    seq_beats(0, 7, 32'h70);
    refill("reset mid", 27'h0999, 3'd6, 1'b0, 3);
    q_idx.delete(); q_dat.delete();
    seq_beats(0, 7, 32'h80);
    refill("after reset", 27'h0321, 3'd7, 1'b0, -1);

    // Last beat coincides with the fall of replace.
    q_idx.delete(); q_dat.delete();
    seq_beats(0, 7, 32'hE0);
    refill("last on fall", 27'h0f0f, 3'd3, 1'b1, -1);

    // Randomized refills: shuffled order, dropped beats, retried beats.
    for (int t = 0; t < 30; t++) begin
      q_idx.delete(); q_dat.delete();
      for (int k = 0; k < NBEATS; k++) perm[k] = k;
      for (int k = NBEATS - 1; k > 0; k--) begin
        int j, tmp;
        j = int'($urandom_range(0, k));
        tmp = perm[k]; perm[k] = perm[j]; perm[j] = tmp;
      end
      for (int k = 0; k < NBEATS; k++) begin
        if ($urandom_range(0, 9) != 0) begin
          q_idx.push_back(perm[k]);
          q_dat.push_back($urandom);
        end
        if ($urandom_range(0, 5) == 0) begin
          q_idx.push_back(int'($urandom_range(0, NBEATS - 1)));
          q_dat.push_back($urandom);
        end
      end
      if (q_idx.size() == 0) begin
        q_idx.push_back(0);
        q_dat.push_back($urandom);
      end
      refill($sformatf("rand%0d", t), 27'($urandom), 3'($urandom),
             1'($urandom), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/line_fill_buffer.md
LINE_FILL_BUFFER -- requirements
Module: line_fill_buffer

Interface
REQ-001 SHALL have parameter FE_ADDR_W, default 32, meaning frontend address width.
REQ-002 SHALL have parameter FE_DATA_W, default 32, meaning frontend word width.
REQ-003 SHALL have parameter BE_DATA_W, default 32, meaning backend beat width; it is a multiple of FE_DATA_W.
REQ-004 SHALL have parameter WORD_OFF_W, default 3, meaning log2 of frontend words per line.
REQ-005 SHALL derive localparams BE_BYTE_W=$clog2(BE_DATA_W/8), LINE2MEM_W=WORD_OFF_W-$clog2(BE_DATA_W/FE_DATA_W) and LINE_W=FE_DATA_W*2**WORD_OFF_W; LINE2MEM_W>=1 is required.
REQ-006 SHALL have port clk, input, 1 bit: the single clock.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port replace, input, 1 bit: refill in progress, from the AXI read channel.
REQ-009 SHALL have port fill_addr, input, [FE_ADDR_W-1:BE_BYTE_W+LINE2MEM_W]: line address of the refill.
REQ-010 SHALL have port fill_word_off, input, WORD_OFF_W bits: critical word offset.
REQ-011 SHALL have port read_valid, input, 1 bit: beat valid.
REQ-012 SHALL have port read_addr, input, LINE2MEM_W bits: beat index within the line.
REQ-013 SHALL have port read_rdata, input, BE_DATA_W bits: beat data.
REQ-014 SHALL have port line_we, output, 1 bit: one-cycle data-memory write strobe.
REQ-015 SHALL have port line_addr, output, same width as fill_addr: line address to write.
REQ-016 SHALL have port line_wdata, output, LINE_W bits: assembled line.
REQ-017 SHALL have port fill_err, output, 1 bit: one-cycle pulse when an incomplete refill is discarded.
REQ-018 SHALL have port fwd_valid, output, 1 bit: critical word available.
REQ-019 SHALL have port fwd_rdata, output, FE_DATA_W bits: critical word.

Function
REQ-020 SHALL implement states IDLE, FILL and COMMIT.
REQ-021 SHALL, in IDLE with replace=1, capture fill_addr into line_addr and fill_word_off, clear the beat-valid bitmap, and go to FILL on the next edge.
REQ-022 SHALL, in FILL on read_valid=1, write read_rdata into beat slot read_addr and set bitmap[read_addr]; a repeated index overwrites the slot (error-retry case).
REQ-023 SHALL, in FILL with replace=0 and the bitmap all ones, go to COMMIT.
REQ-024 SHALL, in FILL with replace=0 and the bitmap not full, return to IDLE, pulse fill_err for one cycle, and leave line_we at 0.
REQ-025 SHALL, in COMMIT, hold line_we=1 for exactly one cycle with line_wdata and line_addr stable, then go to IDLE.
REQ-026 SHALL, when read_valid coincides with replace=0 in FILL, store that beat before the completeness check.
REQ-027 SHALL place beat k at line_wdata[k*BE_DATA_W +: BE_DATA_W].
REQ-028 SHALL ignore read_valid outside FILL.
REQ-029 SHALL ignore replace in COMMIT; a new refill is accepted only from IDLE.

Reset
REQ-030 SHALL, on reset=1 at a clk edge, set state=IDLE, bitmap=0, line_we=0, fill_err=0, fwd_valid=0, line_addr=0, line_wdata=0 and fwd_rdata=0.
REQ-031 SHALL, on reset mid-FILL, discard the partial line with no line_we and no fill_err.

Configuration
REQ-032 SHALL, with CACHE_FILL_FWD_EN defined, pulse fwd_valid for one cycle, one cycle after the beat holding the captured critical word is accepted, with fwd_rdata set to that FE_DATA_W slice.
REQ-033 SHALL pulse fwd_valid at most once per refill; a retried beat does not re-pulse it.
REQ-034 SHALL, without CACHE_FILL_FWD_EN, tie fwd_valid and fwd_rdata to 0 and synthesize no forwarding registers.

Structure
REQ-035 SHALL take state encodings and the LINE2MEM_W/LINE_W derivation from the shared package iob_cache_pkg.
REQ-036 SHALL contain no sub-module; the beat storage and bitmap are plain registers.

Verification (FE=BE=32, WORD_OFF_W=3, 8 beats)
REQ-037 SHALL verify: refill at fill_addr=0x1234 with beats 0..7 = 0xA0..0xA7, then replace falls -> exactly one line_we, line_addr=0x1234, line_wdata[31:0]=0xA0 and [255:224]=0xA7.
REQ-038 SHALL verify: replace falls after 5 beats -> fill_err pulses once, line_we stays 0, and the state returns to IDLE.
REQ-039 SHALL verify: retry where beats 0..3 = 0xB*, restart from 0 with beats 0..7 = 0xC* -> committed line is all 0xC*.
REQ-040 SHALL verify, with CACHE_FILL_FWD_EN: fill_word_off=5, beat 5 = 0xDEAD accepted in cycle t -> fwd_valid=1 in t+1 only and fwd_rdata=0xDEAD; without the macro, fwd_valid stays 0.
REQ-041 SHALL verify: reset asserted after beat 3 -> no line_we and no fill_err, and a following full refill commits correctly.
REQ-042 SHALL verify: last beat arrives in the same cycle replace falls -> COMMIT with the last beat included.
